// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_port peripheral.
package uart_pkg;
  localparam int DATA_BITS   = 8;
  localparam int ERR_FRAME   = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_TX_OVF  = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO; head reads as zero when empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, count;
  logic             do_push, do_pop;

  // Pointers carry one extra bit so count wraps modulo 2*DEPTH.
  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_port.sv
// CPU-side 8N1 UART: TX/RX FIFOs, serialiser, deserialiser, sticky errors.
module uart_port
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       _wr,
  input  logic       _rd,
  output logic [7:0] data_out,
  output logic       flag_di,
  output logic       flag_do,
  output logic       tx,
  input  logic       rx,
  input  logic       clr_err,
  output logic [2:0] err
);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_END = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_MID = TW'(CLK_DIV / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic       wr, rd;
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic       rx_full, rx_empty, rx_push;
  logic [7:0] tx_head;
  logic [2:0] err_set;

  tx_state_t  tx_st;
  logic [TW-1:0] tx_tmr;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;

  rx_state_t  rx_st;
  logic [TW-1:0] rx_tmr;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic       rx_s1, rx_s2, rx_prev;

  assign wr      = !_wr;
  assign rd      = !_rd;
  assign tx_push = wr && !tx_full;
  assign tx_pop  = !tx_empty &&
                   ((tx_st == TX_IDLE) || (tx_st == TX_STOP && tx_tmr == T_END));
  assign rx_push = (rx_st == RX_STOP) && (rx_tmr == T_END) && rx_s2;

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(reset), .push(tx_push), .pop(tx_pop), .din(data_in),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(reset), .push(rx_push), .pop(rd), .din(rx_sh),
    .head(data_out), .full(rx_full), .empty(rx_empty)
  );

  assign flag_di = !rx_empty;
  assign flag_do = !tx_full;

  always_comb begin
    err_set              = '0;
    err_set[ERR_TX_OVF]  = wr && tx_full;
    // Overrun only when no CPU pop makes room on the same edge.
    err_set[ERR_OVERRUN] = rx_push && rx_full && !rd;
    err_set[ERR_FRAME]   = (rx_st == RX_STOP) && (rx_tmr == T_END) && !rx_s2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else       err <= (clr_err ? 3'b000 : err) | err_set;
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= TX_IDLE;
      tx_tmr <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      tx     <= 1'b1;
    end else begin
      tx <= (tx_st == TX_START) ? 1'b0 : (tx_st == TX_DATA) ? tx_sh[0] : 1'b1;
      if (tx_st == TX_IDLE) tx_tmr <= '0;
      else                  tx_tmr <= (tx_tmr == T_END) ? '0 : tx_tmr + 1'b1;
      case (tx_st)
        TX_IDLE: if (tx_pop) begin
          tx_sh <= tx_head;
          tx_st <= TX_START;
        end
        TX_START: if (tx_tmr == T_END) begin
          tx_bit <= '0;
          tx_st  <= TX_DATA;
        end
        TX_DATA: if (tx_tmr == T_END) begin
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == LAST_BIT) tx_st <= TX_STOP;
        end
        TX_STOP: if (tx_tmr == T_END) begin
          if (tx_pop) begin
            tx_sh <= tx_head;
            tx_st <= TX_START;
          end else begin
            tx_st <= TX_IDLE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_tmr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_st)
        RX_IDLE: begin
          rx_tmr <= '0;
          if (rx_prev && !rx_s2) rx_st <= RX_START;
        end
        RX_START: begin
          rx_tmr <= rx_tmr + 1'b1;
          if (rx_tmr == T_MID) begin
            rx_tmr <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_tmr <= rx_tmr + 1'b1;
          if (rx_tmr == T_END) begin
            rx_tmr <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == LAST_BIT) rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_tmr <= rx_tmr + 1'b1;
          if (rx_tmr == T_END) begin
            rx_tmr <= '0;
            rx_st  <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: if (rx_s2) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_port.sv
// Scoreboard bench for uart_port: TX frames decoded off the line, RX reads checked against a byte queue.
module tb_uart_port;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_n, rd_n, clr_err, rx_drv, loop;
  logic       rx;
  logic [7:0] data_out;
  logic       flag_di, flag_do, tx;
  logic [2:0] err;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];
  logic [7:0] rd_e;

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  uart_port dut (
    .clk(clk), .reset(rst), .data_in(data_in), ._wr(wr_n), ._rd(rd_n),
    .data_out(data_out), .flag_di(flag_di), .flag_do(flag_do), .tx(tx),
    .rx(rx), .clr_err(clr_err), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic sync_pos();
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    data_in = b; wr_n = 1'b0;
    @(posedge clk); #1 wr_n = 1'b1;
  endtask

  task automatic rd_byte();
    rd_n = 1'b0;
    @(posedge clk); #1 rd_n = 1'b1;
  endtask

  task automatic clr();
    clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  // Serial driver: one bit every 16 clocks, changes on falling clk edges.
  task automatic send_rx(input logic [7:0] b, input logic sb);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = sb;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (tx_exp.size() != 0 && n < lim) begin
      @(posedge clk); n++;
    end
    chk("tx_drained", tx_exp.size(), 0);
    repeat (40) @(posedge clk);
    #1;
  endtask

  // Line-level frame decoder: mid-bit samples from the falling start edge.
  initial begin
    logic [7:0] b, e;
    logic st, sp;
    forever begin
      @(negedge tx);
      repeat (8) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
      repeat (16) @(negedge clk);
      sp = tx;
      if (mon_en) begin
        if (tx_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_unexpected: got frame %02h, required none", b);
        end else begin
          e = tx_exp.pop_front();
          chk("tx_byte", b, e);
          chk("tx_start_stop", {st, sp}, 2'b01);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rd_n) begin
      if (rx_model.size() == 0) begin
        chk("rd_empty_data", data_out, 0);
        chk("rd_empty_di", flag_di, 0);
      end else begin
        rd_e = rx_model.pop_front();
        chk("rd_data", data_out, rd_e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] pat [4];
    int n;
    pat = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    rst = 1'b1; wr_n = 1'b1; rd_n = 1'b1; clr_err = 1'b0;
    rx_drv = 1'b1; loop = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_flag_do", flag_do, 1);
    chk("rst_flag_di", flag_di, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    sync_pos();

    // Async reset in the middle of a TX frame and an RX frame.
    wr_byte(8'h00);
    @(negedge clk);
    fork
      send_rx(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2;
        chk("t1_tx_low_before", tx, 0);
        rst = 1'b1;
        #1;
        chk("t1_tx", tx, 1);
        chk("t1_flag_do", flag_do, 1);
        chk("t1_flag_di", flag_di, 0);
        chk("t1_err", err, 0);
        chk("t1_data_out", data_out, 0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    repeat (200) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // TX start latency and back-to-back frame length.
    wr_byte(8'hA5);
    tx_exp.push_back(8'hA5);
    sync_pos();
    chk("t2_tx_edge_n1", tx, 1);
    sync_pos();
    chk("t2_tx_edge_n2", tx, 0);
    b = 8'($urandom);
    wr_byte(b);
    tx_exp.push_back(b);
    repeat (158) @(posedge clk);
    #1;
    chk("t2_stop_bit", tx, 1);
    sync_pos();
    chk("t2_no_gap_start", tx, 0);
    drain(400);

    // Loopback of boundary bytes.
    loop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_byte(pat[i]);
      tx_exp.push_back(pat[i]);
      rx_model.push_back(pat[i]);
    end
    n = 0;
    while (!flag_di && n < 400) begin
      sync_pos(); n++;
    end
    chk("t3_flag_di_rise", flag_di, 1);
    chk("t3_err_first", err, 0);
    drain(800);
    chk("t3_err_end", err, 0);
    repeat (4) rd_byte();
    rd_byte();
    chk("t3_empty_di", flag_di, 0);
    loop = 1'b0;

    // TX overflow while a frame is in flight.
    b = 8'($urandom);
    wr_byte(b);
    tx_exp.push_back(b);
    repeat (4) sync_pos();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      wr_byte(b);
      tx_exp.push_back(b);
    end
    chk("t4_flag_do_full", flag_do, 0);
    wr_byte(8'($urandom));
    chk("t4_err_ovf", err, 3'b100);
    chk("t4_flag_do_still", flag_do, 0);
    clr();
    chk("t4_err_clr", err, 0);
    data_in = 8'($urandom); wr_n = 1'b0; clr_err = 1'b1;
    @(posedge clk); #1 wr_n = 1'b1; clr_err = 1'b0;
    chk("t4_err_wins_clr", err, 3'b100);
    clr();
    chk("t4_err_clr2", err, 0);
    drain(1200);
    chk("t4_flag_do_room", flag_do, 1);

    // RX overrun, framing error, glitch rejection.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      if (i < 4) rx_model.push_back(b);
    end
    sync_pos();
    chk("t5_err_overrun", err, 3'b010);
    chk("t5_flag_di", flag_di, 1);
    repeat (4) rd_byte();
    rd_byte();
    chk("t5_empty_di", flag_di, 0);
    chk("t5_empty_do", flag_do, 1);
    chk("t5_empty_data", data_out, 0);
    clr();
    chk("t5_err_clr", err, 0);
    @(negedge clk);
    send_rx(8'($urandom), 1'b0);
    sync_pos();
    chk("t5_err_frame", err, 3'b001);
    chk("t5_frame_no_push", flag_di, 0);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    sync_pos();
    chk("t5_glitch_err", err, 3'b001);
    chk("t5_glitch_di", flag_di, 0);
    clr();
    @(negedge clk);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    rx_model.push_back(b);
    sync_pos();
    chk("t5_recover_di", flag_di, 1);
    rd_byte();
    chk("t5_recover_err", err, 0);

    // Pop and push on the same edge with the RX FIFO full.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      rx_model.push_back(b);
    end
    b = 8'($urandom);
    fork
      send_rx(b, 1'b1);
      begin
        // Aim the pop at the edge where the stop-bit sample lands.
        repeat (153) @(negedge clk);
        @(posedge clk); #1 rd_n = 1'b0;
        @(posedge clk); #1 rd_n = 1'b1;
      end
    join
    rx_model.push_back(b);
    sync_pos();
    chk("t6_err", err, 0);
    chk("t6_flag_di", flag_di, 1);
    repeat (4) rd_byte();
    rd_byte();
    chk("t6_empty_di", flag_di, 0);
    chk("t6_empty_do", flag_do, 1);

    chk("end_tx_queue", tx_exp.size(), 0);
    chk("end_rx_queue", rx_model.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
